// File: rtl/mem_port_arbiter_if.sv
// Unified memory port bundle: fetch and data requesters plus the memory side.
// The arbiter takes the slave view; fetch/LSU/memory take the master view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              stall;
   logic              err;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
      input  mem_rdata, mem_ready,
      output if_rdata, if_valid, d_rdata, d_valid,
      output mem_en, mem_we, mem_addr, mem_wdata, stall, err
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
      output mem_rdata, mem_ready,
      input  if_rdata, if_valid, d_rdata, d_valid,
      input  mem_en, mem_we, mem_addr, mem_wdata, stall, err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between fetch and load/store,
// with alternating priority under contention and a busy-state timeout.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_d_q, last_d_d;
   logic              en_q, en_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] ird_q, ird_d;
   logic [DATA_W-1:0] drd_q, drd_d;
   logic              iv_q, iv_d;
   logic              dv_q, dv_d;
   logic              err_q, err_d;
   logic              i_go, d_go, pick_d;

   // A requester is masked while its own completion pulse is visible
   assign i_go   = bus.if_req & ~iv_q;
   assign d_go   = bus.d_req & ~dv_q;
   assign pick_d = d_go & ~(i_go & last_d_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d_d = last_d_q;
      en_d     = en_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ird_d    = ird_q;
      drd_d    = drd_q;
      iv_d     = 1'b0;
      dv_d     = 1'b0;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (pick_d) begin
               state_d  = BUSY_D;
               last_d_d = 1'b1;
               en_d     = 1'b1;
               we_d     = bus.d_we;
               addr_d   = bus.d_addr;
               wdata_d  = bus.d_wdata;
               cnt_d    = '0;
            end else if (i_go) begin
               state_d  = BUSY_I;
               last_d_d = 1'b0;
               en_d     = 1'b1;
               we_d     = 1'b0;
               addr_d   = bus.if_addr;
               cnt_d    = '0;
            end
         end
         BUSY_I, BUSY_D: begin
            if (bus.mem_ready || cnt_q == CNT_LAST) begin
               state_d = IDLE;
               en_d    = 1'b0;
               we_d    = 1'b0;
               if (state_q == BUSY_I) begin
                  iv_d  = 1'b1;
                  ird_d = bus.mem_ready ? bus.mem_rdata : '0;
               end else begin
                  dv_d = 1'b1;
                  if (!bus.mem_ready) drd_d = '0;
                  else if (!we_q) drd_d = bus.mem_rdata;
               end
               if (!bus.mem_ready) err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         last_d_q <= 1'b0;
         en_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         ird_q    <= '0;
         drd_q    <= '0;
         iv_q     <= 1'b0;
         dv_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_d_q <= last_d_d;
         en_q     <= en_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ird_q    <= ird_d;
         drd_q    <= drd_d;
         iv_q     <= iv_d;
         dv_q     <= dv_d;
         err_q    <= err_d;
      end
   end

   assign bus.mem_en    = en_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_rdata  = ird_q;
   assign bus.if_valid  = iv_q;
   assign bus.d_rdata   = drd_q;
   assign bus.d_valid   = dv_q;
   assign bus.err       = err_q;
   assign bus.stall     = i_go | d_go;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between instruction fetch (IF) and load/store data access (D).
- Sits between the fetch/LSU logic and the memory.
- Grants one access at a time, waits for the memory's ready handshake and returns read data to the right requester.
- Aborts any access the memory fails to complete within a bounded time, and flags it.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, max cycles in a busy state without mem_ready before abort (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_rdata  out  DATA_W  fetched instruction word
- if_valid  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1 = store, 0 = load (MemRW)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_valid  out  1  one-cycle completion pulse for data
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes access this cycle
- stall  out  1  pipeline hold
- err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. All outputs except stall are registered.
- Reset (synchronous, rst_n=0 at a clk edge): state=IDLE; mem_en, mem_we, if_valid, d_valid, err, timeout counter and last_was_d cleared; mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- Arbitration in IDLE:
  - d_req alone → BUSY_D. if_req alone → BUSY_I.
  - Both pending → D wins, unless last_was_d=1, in which case IF wins. Consequence: a waiting fetch is never starved by more than one data access.
  - last_was_d updates on each grant (1 for D, 0 for IF).
- Grant timing: on the grant edge, mem_en=1, mem_addr and mem_wdata are latched from the winner, and mem_we = d_we for D or 0 for IF. These are held constant for the whole busy state.
- Completion (BUSY_x with mem_ready=1):
  - At the edge, latch mem_rdata into x_rdata for loads and fetches; stores leave d_rdata unchanged.
  - x_valid=1 for exactly one cycle; mem_en, mem_we cleared; state→IDLE.
- Minimum latency: req at cycle 0 → mem_en cycle 1 → ready cycle 1 → x_valid cycle 2. Back-to-back accesses from IDLE therefore occur every 2 cycles.
- Request masking: a requester's req is ignored in the cycle its own x_valid is high, so it can drop req or present a new address without a duplicate grant. The other requester may be granted in that cycle.
- Timeout:
  - Counter clears on grant and increments each busy cycle without mem_ready.
  - When it reaches TIMEOUT: abort. x_valid pulses, x_rdata=0, err←1 (sticky until reset), mem_en←0, state→IDLE.
  - mem_ready in the same cycle as the TIMEOUT count takes precedence: normal completion, no err.
- stall (combinational) = (if_req & ~if_valid) | (d_req & ~d_valid).
- A req dropped before valid is a protocol violation. The arbiter still completes the granted access; the result is undefined.
- Reset mid-access: abandon immediately to IDLE. No valid pulse; mem_en low the following cycle.
- Address and data widths pass through unmodified; no alignment checks.

Test Plan:
- IF only, if_addr=0x00000010, mem_ready on first mem_en cycle, mem_rdata=0x00500093 → mem_en cycle 1, if_valid cycle 2, if_rdata=0x00500093, mem_we=0, stall high cycles 0–1.
- Simultaneous IF 0x14 and D load 0x100, ready immediate → D granted first; d_valid cycle 2, then IF granted cycle 2, if_valid cycle 4.
- d_req held continuously with back-to-back loads while if_req pending → grant order D, IF, D, IF; never two consecutive D grants while IF waits.
- Store: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, 3 wait cycles → mem_we=1 and mem_addr/mem_wdata stable 4 cycles; d_valid pulses once; d_rdata unchanged.
- mem_ready never asserted, TIMEOUT=15 → abort after 15 busy cycles; if_valid pulse, if_rdata=0, err=1 and stays 1; next request serviced normally. Variant: ready on the 15th cycle → no err.
- rst_n=0 during BUSY_D with 2 wait cycles elapsed → next edge: IDLE, mem_en=0, no d_valid, err=0.
